// File: rtl/out_port_seg_pkg.sv
// Shared types and segment constants for the decimal output-port display.
// Segments are active-low; bit 0 = segment a ... bit 6 = segment g.
package out_port_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // 10^n as a 64-bit constant; valid for n <= 19.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_seg7_enc.sv
// Combinational BCD digit to active-low seven-segment encoder.
// Non-decimal codes 10..15 render as blank.
module bcd_seg7_enc
  import out_port_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/out_port_dec_seg.sv
// Iterative double-dabble converter driving DIGITS active-low 7-seg digits.
// Define OUT_DEC_SEG_LZB_EN to blank leading zero digits (units always shown).
module out_port_dec_seg
  import out_port_seg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value_in,
  output logic [DIGITS*7-1:0]   hex_out,
  output logic                  busy,
  output logic                  update,
  output logic                  overflow,
  output state_t                dbg_state
);

  localparam int          CMP_W  = (DATA_W > 64) ? DATA_W : 64;
  localparam int          CNT_W  = $clog2(DATA_W + 1);
  localparam int          BCD_W  = DIGITS * 4;
  localparam logic [63:0] POW10  = pow10(DIGITS);

  state_t              state;
  logic [DATA_W-1:0]   sreg;
  logic [DATA_W-1:0]   last_val;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    cnt;
  logic                prime;
  logic                ovf_pend;
  logic                ovf_now;
  logic [DIGITS*7-1:0] seg_raw;
  logic [DIGITS*7-1:0] seg_disp;

  assign dbg_state = state;

  // Both sides widened so the limit never truncates when 10^DIGITS > 2^DATA_W.
  assign ovf_now = (CMP_W'(value_in) >= CMP_W'(POW10));

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    bcd_seg7_enc u_enc (
      .bcd (bcd[g*4 +: 4]),
      .seg (seg_raw[g*7 +: 7])
    );
  end

`ifdef OUT_DEC_SEG_LZB_EN
  logic [DIGITS-1:0] lead_zero;
  logic              above_zero;

  // lead_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    lead_zero  = '0;
    above_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero   = above_zero & (bcd[i*4 +: 4] == 4'd0);
      lead_zero[i] = above_zero;
    end
  end
`endif

  always_comb begin
    seg_disp = seg_raw;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_pend) seg_disp[i*7 +: 7] = SEG_DASH;
`ifdef OUT_DEC_SEG_LZB_EN
      else if (i != 0 && lead_zero[i]) seg_disp[i*7 +: 7] = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      last_val <= '0;
      bcd      <= '0;
      cnt      <= '0;
      prime    <= 1'b1;
      ovf_pend <= 1'b0;
      hex_out  <= {DIGITS{SEG_BLANK}};
      busy     <= 1'b0;
      update   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (prime || (value_in != last_val)) begin
            sreg     <= value_in;
            last_val <= value_in;
            ovf_pend <= ovf_now;
            bcd      <= '0;
            prime    <= 1'b0;
            cnt      <= CNT_W'(DATA_W);
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Top-nibble carry falls off: the result is value mod 10^DIGITS.
          bcd  <= {bcd_adj[BCD_W-2:0], sreg[DATA_W-1]};
          sreg <= {sreg[DATA_W-2:0], 1'b0};
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_LOAD;
        end
        ST_LOAD: begin
          hex_out  <= seg_disp;
          overflow <= ovf_pend;
          update   <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_dec_seg.sv
// Directed bench for out_port_dec_seg: reset, latency, values, overflow,
// mid-conversion value change and mid-conversion reset.
module tb_out_port_dec_seg;
  import out_port_seg_pkg::*;

  localparam int DATA_W = 32;
  localparam int DIGITS = 2;
  localparam int LAT    = DATA_W + 2;  // sample edge + DATA_W shifts + load edge

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;
`ifdef OUT_DEC_SEG_LZB_EN
  localparam logic [6:0] LZ = SB;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [DATA_W-1:0]    value_in = '0;
  logic [DIGITS*7-1:0]  hex_out;
  logic                 busy;
  logic                 update;
  logic                 overflow;
  state_t               dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  out_port_dec_seg #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .value_in  (value_in),
    .hex_out   (hex_out),
    .busy      (busy),
    .update    (update),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts posedges until update is seen at a negedge; -1 on timeout.
  task automatic wait_update(output int edges, output logic busy_first);
    edges = 0;
    busy_first = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) busy_first = busy;
      if (update) return;
    end
    edges = -1;
  endtask

  // vectors applied back-to-back
  logic [31:0] vec_val [9] = '{32'd42, 32'd100, 32'hFFFFFFFF, 32'd99, 32'd10,
                               32'd7, 32'd0, 32'd5, 32'd200};
  logic [13:0] vec_hex [9] = '{{S4, S2}, {SD, SD}, {SD, SD}, {S9, S9}, {S1, S0},
                               {LZ, S7}, {LZ, S0}, {LZ, S5}, {SD, SD}};
  logic        vec_ovf [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int   e;
    int   pulses;
    logic bf;

    value_in = 32'd0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hex", 32'(hex_out), 32'h3FFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // first conversion after reset runs even though value_in equals last_val
    reset = 1'b1;
    wait_update(e, bf);
    check("prime_latency", 32'(e), 32'(LAT));
    check("prime_busy", 32'(bf), 32'd1);
    check("prime_hex", 32'(hex_out), 32'({LZ, S0}));
    check("prime_busy_done", 32'(busy), 32'd0);

    for (int k = 0; k < 9; k++) begin
      value_in = vec_val[k];
      exp_q.push_back(32'(vec_hex[k]));
      wait_update(e, bf);
      check($sformatf("v%0d_latency", k), 32'(e), 32'(LAT));
      check($sformatf("v%0d_busy", k), 32'(bf), 32'd1);
      check($sformatf("v%0d_hex", k), 32'(hex_out), exp_q.pop_front());
      check($sformatf("v%0d_ovf", k), 32'(overflow), 32'(vec_ovf[k]));
      if (k == 0) begin
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (update) pulses++;
        end
        check("v0_single_update", 32'(pulses), 32'd0);
      end
    end

    // change during conversion: 37 shown first, 59 picked up on the next pass
    value_in = 32'd37;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    value_in = 32'd59;
    wait_update(e, bf);
    check("chg_first_edges", 32'(e), 32'(LAT - 10));
    check("chg_first_hex", 32'(hex_out), 32'({S3, S7}));
    wait_update(e, bf);
    check("chg_second_edges", 32'(e), 32'(LAT));
    check("chg_second_hex", 32'(hex_out), 32'({S5, S9}));

    // show an overflow so the reset clearing it is observable
    value_in = 32'd200;
    wait_update(e, bf);
    check("pre_rst_ovf", 32'(overflow), 32'd1);

    value_in = 32'd85;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_hex", 32'(hex_out), 32'h3FFF);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_update(e, bf);
    check("postrst_latency", 32'(e), 32'(LAT));
    check("postrst_hex", 32'(hex_out), 32'({S8, S5}));
    check("postrst_ovf", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
